// File: rtl/apb_master_pkg.sv
// Shared types and default parameter values for the APB requester.
// Sized for TIMEOUT_CYCLES up to 255.
package apb_master_pkg;

   localparam int unsigned DefDataWidth     = 32;
   localparam int unsigned DefAddrWidth     = 16;
   localparam int unsigned DefTimeoutCycles = 16;
   localparam int unsigned WaitCntWidth     = 8;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } apb_state_e;

   // Counter value seen in the last ACCESS cycle that is still allowed to complete.
   function automatic logic [WaitCntWidth-1:0] timeout_limit(input int unsigned cycles);
      return WaitCntWidth'(cycles - 1);
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the ACCESS phase: clear, increment, and a flag when the
// final allowed ACCESS cycle has been reached.
module apb_timeout_cnt import apb_master_pkg::*; #(
   parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   logic [WaitCntWidth-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == timeout_limit(TimeoutCycles));

   // Saturates at the limit so a stalled FSM can never wrap the count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response back.
// ACCESS aborts with a timeout response if PREADY stays low for TIMEOUT_CYCLES cycles.
module apb_master import apb_master_pkg::*; #(
   parameter int unsigned DATA_WIDTH     = DefDataWidth,
   parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   // Command channel
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // Response channel
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_timeout,
   // APB requester side
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSELx,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PENABLE,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA
);

   apb_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  timeout_q, timeout_d;
   logic                  cnt_clr, cnt_inc, cnt_expired;

   apb_timeout_cnt #(
      .TimeoutCycles (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk_i     (PCLK),
      .rst_i     (PRESET),
      .clr_i     (cnt_clr),
      .inc_i     (cnt_inc),
      .expired_o (cnt_expired)
   );

   // Handshake and bus strobes decode straight from state so reset drops them at once.
   assign cmd_ready   = (state_q == StIdle);
   assign rsp_valid   = (state_q == StResp);
   assign PSELx       = (state_q == StSetup) || (state_q == StAccess);
   assign PENABLE     = (state_q == StAccess);
   assign PADDR       = paddr_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_timeout = timeout_q;

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      timeout_d = timeout_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            cnt_clr = 1'b1;
            state_d = StAccess;
         end
         StAccess: begin
            // PREADY wins over the timeout in the last allowed cycle.
            if (PREADY) begin
               rdata_d   = pwrite_q ? '0 : PRDATA;
               timeout_d = 1'b0;
               state_d   = StResp;
            end else if (cnt_expired) begin
               rdata_d   = '0;
               timeout_d = 1'b1;
               state_d   = StResp;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= StIdle;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         rdata_q   <= rdata_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed and random transfers against a
// command-level memory model, with a simple APB completer driving PREADY/PRDATA.
module tb_apb_master;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned TO = 16;
   localparam int NEVER = 1000;

   logic          PCLK;
   logic          PRESET;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_timeout;
   logic [AW-1:0] PADDR;
   logic          PSELx;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic          PENABLE;
   logic          PREADY;
   logic [DW-1:0] PRDATA;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] slave_mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];

   apb_master #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_timeout (rsp_timeout),
      .PADDR       (PADDR),
      .PSELx       (PSELx),
      .PWRITE      (PWRITE),
      .PWDATA      (PWDATA),
      .PENABLE     (PENABLE),
      .PREADY      (PREADY),
      .PRDATA      (PRDATA)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Completer memory: a write lands when the ACCESS phase completes.
   always @(posedge PCLK) begin
      if (PSELx && PENABLE && PREADY && PWRITE) slave_mem[PADDR] <= PWDATA;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic recover();
      PRESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      @(negedge PCLK);
   endtask

   // Runs one command from the IDLE negedge to the negedge after the response handshake.
   // waits = PREADY-low ACCESS cycles before the completer responds.
   task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int waits, input int rdelay,
                       input bit pend, input bit pwr, input logic [AW-1:0] paddr,
                       input logic [DW-1:0] pwd);
      int            acc;
      int            cyc;
      int            err0;
      bit            exp_to;
      int            exp_acc;
      logic [DW-1:0] exp_rd;

      err0    = errors;
      exp_to  = (waits >= TO);
      exp_acc = exp_to ? TO : waits + 1;
      exp_rd  = (wr || exp_to) ? '0 : (ref_mem.exists(addr) ? ref_mem[addr] : '0);
      if (wr && !exp_to) ref_mem[addr] = wd;

      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      check("cmd_ready_idle", cmd_ready, 1);
      check("psel_idle", PSELx, 0);
      check("penable_idle", PENABLE, 0);
      @(posedge PCLK); @(negedge PCLK); cyc = 1;

      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
      check("setup_psel", PSELx, 1);
      check("setup_penable", PENABLE, 0);
      check("setup_paddr", PADDR, addr);
      check("setup_pwrite", PWRITE, wr);
      check("setup_pwdata", PWDATA, wd);
      check("setup_cmd_ready", cmd_ready, 0);
      @(posedge PCLK); @(negedge PCLK); cyc++;

      acc = 0;
      while (PSELx === 1'b1 && PENABLE === 1'b1 && acc < 300) begin
         acc++;
         check("access_paddr", PADDR, addr);
         check("access_pwrite", PWRITE, wr);
         check("access_pwdata", PWDATA, wd);
         check("access_rsp_valid", rsp_valid, 0);
         check("access_cmd_ready", cmd_ready, 0);
         cmd_addr = AW'($urandom); cmd_wdata = $urandom;
         PREADY = (acc - 1 == waits);
         PRDATA = PREADY ? slave_mem[PADDR] : $urandom;
         @(posedge PCLK); @(negedge PCLK); cyc++;
         PREADY = 1'b0; PRDATA = $urandom;
      end
      check("access_cycles", acc, exp_acc);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_timeout", rsp_timeout, exp_to);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("resp_psel", PSELx, 0);
      check("resp_penable", PENABLE, 0);

      if (pend) begin
         cmd_valid = 1'b1; cmd_write = pwr; cmd_addr = paddr; cmd_wdata = pwd;
      end
      for (int d = 0; d < rdelay; d++) begin
         rsp_ready = 1'b0;
         @(posedge PCLK); @(negedge PCLK); cyc++;
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_timeout", rsp_timeout, exp_to);
         check("hold_rsp_rdata", rsp_rdata, exp_rd);
         check("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge PCLK); @(negedge PCLK); cyc++;
      rsp_ready = 1'b0;
      check("post_rsp_valid", rsp_valid, 0);
      check("post_paddr_hold", PADDR, addr);
      check("xfer_cycles", cyc, 3 + exp_acc + rdelay);
      if (errors != err0) recover();
   endtask

   task automatic xfer_abort(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int n);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = wd;
      @(posedge PCLK); @(negedge PCLK);
      cmd_valid = 1'b0;
      @(posedge PCLK); @(negedge PCLK);
      PREADY = 1'b0;
      for (int i = 1; i < n; i++) begin
         @(posedge PCLK); @(negedge PCLK);
      end
      check("abort_in_access", PENABLE, 1);
      PRESET = 1'b1;
      #1;
      check("abort_psel", PSELx, 0);
      check("abort_penable", PENABLE, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_paddr", PADDR, 0);
      check("abort_pwdata", PWDATA, 0);
      @(posedge PCLK); @(negedge PCLK);
      check("abort_no_rsp", rsp_valid, 0);
      PRESET = 1'b0;
      @(posedge PCLK); #1;
      check("release_cmd_ready", cmd_ready, 1);
      @(negedge PCLK);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) slave_mem[i] = '0;
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0;
      #1;
      check("rst_psel", PSELx, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      @(negedge PCLK); @(negedge PCLK);
      PRESET = 1'b0;
      @(negedge PCLK);

      // Zero-wait write then read-back
      xfer(1, 16'h0010, 32'hDEADBEEF, 0, 0, 0, 0, '0, '0);
      xfer(0, 16'h0010, 32'h0BAD0BAD, 0, 0, 0, 0, '0, '0);
      // Three wait states
      xfer(1, 16'h0020, 32'h12345678, 3, 0, 0, 0, '0, '0);
      xfer(0, 16'h0020, 32'h0, 3, 1, 0, 0, '0, '0);
      // Completer never ready: timeout on read and write
      xfer(0, 16'h0010, 32'h0, NEVER, 0, 0, 0, '0, '0);
      xfer(1, 16'h0010, 32'hCAFEF00D, NEVER, 0, 0, 0, '0, '0);
      xfer(0, 16'h0010, 32'h0, 0, 0, 0, 0, '0, '0);
      // PREADY in the last allowed cycle is a success, one more is a timeout
      xfer(1, 16'h0030, 32'hA5A55A5A, TO - 1, 0, 0, 0, '0, '0);
      xfer(0, 16'h0030, 32'h0, TO - 1, 0, 0, 0, '0, '0);
      xfer(0, 16'h0030, 32'h0, TO, 0, 0, 0, '0, '0);
      // Slow response consumer with a second command waiting
      xfer(1, 16'h0040, 32'h01020304, 0, 5, 1, 0, 16'h0040, 32'h0);
      xfer(0, 16'h0040, 32'h0, 0, 0, 0, 0, '0, '0);
      // Reset pulse during ACCESS, then normal traffic
      xfer_abort(16'h0050, 32'h55555555, 2);
      xfer(0, 16'h0050, 32'h0, 0, 0, 0, 0, '0, '0);
      xfer(1, 16'h0050, 32'h77778888, 1, 0, 0, 0, '0, '0);
      xfer(0, 16'h0050, 32'h0, 2, 0, 0, 0, '0, '0);

      // Random traffic over a small address window to get read hits
      for (int t = 0; t < 40; t++) begin
         int            r;
         int            w;
         logic [AW-1:0] a;
         r = int'($urandom_range(0, 9));
         if (r < 7) w = r % 4;
         else if (r == 7) w = TO - 1;
         else w = TO + int'($urandom_range(0, 3));
         a = AW'($urandom_range(0, 7) * 4 + 16'h0100);
         xfer(1'($urandom), a, $urandom, w, int'($urandom_range(0, 2)), 0, 0, '0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
